sram_port_arbiter: RTL and testbench

- Shares one SRAM-like request/response port between two SRAM-like masters: m0 = data-side LSU, m1 = instruction-fetch/refill path.
- The downstream port feeds the data port of the SRAM-to-AXI bridge.
- Picks a master per address phase, holds the grant until the address is accepted, and records each accepted transaction's owner in an in-order tag FIFO.
- Routes data_ok/rdata back to the owner in acceptance order.

---
 rtl/sram_arb_pkg.sv | 14 +
 rtl/sram_arb_tag_fifo.sv | 62 ++++++
 rtl/sram_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared encodings and defaults for the two-master SRAM port arbiter.
// Round-robin arbitration in the top is enabled by defining SRAM_ARB_RR_EN.
package sram_arb_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

    localparam int OUTST_DEPTH_DEF = 4;

endpackage

// File: rtl/sram_arb_tag_fifo.sv
// In-order owner-tag FIFO, width 1, with same-cycle push/pop support.
// The head is read combinationally so responses route with zero added latency.
module sram_arb_tag_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = OUTST_DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic             din,
    output logic             dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic             mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_en;
    logic             pop_en;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem_reg[rd_ptr_reg];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_en && !pop_en) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop_en && !push_en) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-master SRAM-like port arbiter with grant lock and in-order response routing.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int OUTST_DEPTH = OUTST_DEPTH_DEF,
    parameter int PTR_W       = $clog2(OUTST_DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,

    output logic        err_unexp
);

    logic           lock_reg;
    logic           lock_id_reg;
    logic           err_reg;
    logic           grant;
    logic           granted_req;
    logic           accept;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_head;
    logic [PTR_W:0] fifo_count;
    logic [1:0]     addr_ok_vec;
    logic [1:0]     data_ok_vec;

`ifdef SRAM_ARB_RR_EN
    logic prio_reg;
`endif

    // With no request pending the m0 fields are presented on the payload bus.
    always_comb begin
        grant = MST_M0;
        if (lock_reg) begin
            grant = lock_id_reg;
        end
`ifdef SRAM_ARB_RR_EN
        else if (m0_req && m1_req) begin
            grant = prio_reg;
        end
`endif
        else if (m1_req && !m0_req) begin
            grant = MST_M1;
        end
    end

    assign granted_req = (grant == MST_M1) ? m1_req : m0_req;
    assign s_req       = granted_req & ~fifo_full;
    assign s_wr        = (grant == MST_M1) ? m1_wr    : m0_wr;
    assign s_size      = (grant == MST_M1) ? m1_size  : m0_size;
    assign s_addr      = (grant == MST_M1) ? m1_addr  : m0_addr;
    assign s_wstrb     = (grant == MST_M1) ? m1_wstrb : m0_wstrb;
    assign s_wdata     = (grant == MST_M1) ? m1_wdata : m0_wdata;

    assign accept = s_req & s_addr_ok;
    assign pop    = s_data_ok & ~fifo_empty;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mst
            assign addr_ok_vec[gi] = accept & (grant == 1'(gi));
            assign data_ok_vec[gi] = pop & (fifo_head == 1'(gi));
        end
    endgenerate

    assign m0_addr_ok = addr_ok_vec[0];
    assign m1_addr_ok = addr_ok_vec[1];
    assign m0_data_ok = data_ok_vec[0];
    assign m1_data_ok = data_ok_vec[1];
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;
    assign err_unexp  = err_reg;

    // A stalled request pins its owner; accept or a dropped req releases the lock.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_reg    <= 1'b0;
            lock_id_reg <= MST_M0;
            err_reg     <= 1'b0;
        end else begin
            lock_reg <= s_req & ~s_addr_ok;
            if (s_req && !s_addr_ok) begin
                lock_id_reg <= grant;
            end
            if (s_data_ok && (fifo_count == '0)) begin
                err_reg <= 1'b1;
            end
        end
    end

`ifdef SRAM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prio_reg <= MST_M0;
        end else if (accept) begin
            prio_reg <= ~grant;
        end
    end
`endif

    sram_arb_tag_fifo #(
        .DEPTH (OUTST_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (pop),
        .din    (grant),
        .dout   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: expected owners are queued at accept
// and popped when the slave responds.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_addr_ok, s_data_ok;
    logic        err_unexp;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    sram_port_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .m0_req     (m0_req),
        .m0_wr      (m0_wr),
        .m0_size    (m0_size),
        .m0_addr    (m0_addr),
        .m0_wstrb   (m0_wstrb),
        .m0_wdata   (m0_wdata),
        .m0_rdata   (m0_rdata),
        .m0_addr_ok (m0_addr_ok),
        .m0_data_ok (m0_data_ok),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_size    (m1_size),
        .m1_addr    (m1_addr),
        .m1_wstrb   (m1_wstrb),
        .m1_wdata   (m1_wdata),
        .m1_rdata   (m1_rdata),
        .m1_addr_ok (m1_addr_ok),
        .m1_data_ok (m1_data_ok),
        .s_req      (s_req),
        .s_wr       (s_wr),
        .s_size     (s_size),
        .s_addr     (s_addr),
        .s_wstrb    (s_wstrb),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .s_addr_ok  (s_addr_ok),
        .s_data_ok  (s_data_ok),
        .err_unexp  (err_unexp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_wr = 0; m0_size = 2'b10; m0_wstrb = 4'hF; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_size = 2'b10; m1_wstrb = 4'hF; m1_wdata = 0;
        m0_addr = 32'h0; m1_addr = 32'h0;
        s_rdata = 0; s_addr_ok = 0; s_data_ok = 0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 0;
        cycle();
        resetn = 1;
        exp_q.delete();
    endtask

    // Single-master accept with the slave ready; payload mux checked too.
    task automatic accept_one(input logic id, input logic [31:0] addr);
        logic [38:0] want_pl;
        want_pl = {id, (id ? 2'b10 : 2'b01), (id ? 4'hC : 4'h3), ~addr};
        if (id) begin
            m1_req = 1; m1_addr = addr; m1_wr = 1; m1_size = 2'b10; m1_wstrb = 4'hC; m1_wdata = ~addr;
        end else begin
            m0_req = 1; m0_addr = addr; m0_wr = 0; m0_size = 2'b01; m0_wstrb = 4'h3; m0_wdata = ~addr;
        end
        s_addr_ok = 1;
        #1;
        checks++;
        if ({m1_addr_ok, m0_addr_ok} !== (id ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL accept_addr_ok id=%0d got=%b want=%b", id, {m1_addr_ok, m0_addr_ok}, (id ? 2'b10 : 2'b01));
        end
        checks++;
        if ({s_wr, s_size, s_wstrb, s_wdata} !== want_pl || s_addr !== addr) begin
            errors++;
            $display("FAIL accept_payload id=%0d got addr=%h pl=%h want addr=%h pl=%h", id, s_addr, {s_wr, s_size, s_wstrb, s_wdata}, addr, want_pl);
        end
        exp_q.push_back(id);
        $display("accept id=%0d addr=%h", id, addr);
        cycle();
        m0_req = 0; m1_req = 0; s_addr_ok = 0;
    endtask

    task automatic resp_drain(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] rd;
            logic        e;
            logic [1:0]  want;
            rd = $urandom;
            s_data_ok = 1; s_rdata = rd;
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_scoreboard got=empty want=entry");
            end else begin
                e = exp_q.pop_front();
                want = e ? 2'b10 : 2'b01;
                if ({m1_data_ok, m0_data_ok} !== want) begin
                    errors++;
                    $display("FAIL resp_route got=%b want=%b", {m1_data_ok, m0_data_ok}, want);
                end
                checks++;
                if ((e ? m1_rdata : m0_rdata) !== rd) begin
                    errors++;
                    $display("FAIL resp_rdata got=%h want=%h", (e ? m1_rdata : m0_rdata), rd);
                end
                $display("resp owner=%0d rdata=%h", e, rd);
            end
            cycle();
            s_data_ok = 0;
        end
    endtask

    task automatic test_reset();
        idle();
        m0_addr = 32'h1234; m1_addr = 32'h5678;
        resetn = 0;
        cycle();
        checks++;
        if ({s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, err_unexp} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=000000", {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, err_unexp});
        end
        checks++;
        if (s_addr !== 32'h1234) begin
            errors++;
            $display("FAIL reset_payload got=%h want=%h", s_addr, 32'h1234);
        end
        resetn = 1;
        $display("reset checked");
    endtask

    task automatic test_single_read();
        do_reset();
        m0_req = 1; m0_addr = 32'h1000; m0_wr = 0; s_addr_ok = 1;
        #1;
        checks++;
        if ({m1_addr_ok, m0_addr_ok, s_req} !== 3'b011 || s_addr !== 32'h1000) begin
            errors++;
            $display("FAIL single_accept got ok=%b addr=%h want ok=011 addr=00001000", {m1_addr_ok, m0_addr_ok, s_req}, s_addr);
        end
        exp_q.push_back(1'b0);
        cycle();
        m0_req = 0; s_addr_ok = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({m1_data_ok, m0_data_ok, m0_addr_ok} !== 3'b000) begin
                errors++;
                $display("FAIL single_quiet cyc=%0d got=%b want=000", i, {m1_data_ok, m0_data_ok, m0_addr_ok});
            end
            cycle();
        end
        s_data_ok = 1; s_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({m1_data_ok, m0_data_ok} !== 2'b01 || m0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_resp got ok=%b rdata=%h want ok=01 rdata=deadbeef", {m1_data_ok, m0_data_ok}, m0_rdata);
        end
        void'(exp_q.pop_front());
        cycle();
        s_data_ok = 0;
        #1;
        checks++;
        if ({m1_data_ok, m0_data_ok} !== 2'b00) begin
            errors++;
            $display("FAIL single_resp_once got=%b want=00", {m1_data_ok, m0_data_ok});
        end
        $display("single read done");
    endtask

    task automatic test_arbitration();
        do_reset();
        m0_req = 1; m1_req = 1; m0_addr = 32'hA000; m1_addr = 32'hB000; s_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            logic id;
`ifdef SRAM_ARB_RR_EN
            id = i[0];
`else
            id = 1'b0;
`endif
            #1;
            checks++;
            if ({m1_addr_ok, m0_addr_ok} !== (id ? 2'b10 : 2'b01) || s_addr !== (id ? 32'hB000 : 32'hA000)) begin
                errors++;
                $display("FAIL arb_grant n=%0d got ok=%b addr=%h want id=%0d", i, {m1_addr_ok, m0_addr_ok}, s_addr, id);
            end
            exp_q.push_back(id);
            $display("arb accept n=%0d id=%0d", i, id);
            cycle();
        end
        m0_req = 0; m1_req = 0; s_addr_ok = 0;
        resp_drain(4);
    endtask

    task automatic test_lock();
        do_reset();
        m1_req = 1; m1_addr = 32'h2000; m0_addr = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (s_addr !== 32'h2000 || s_req !== 1'b1 || {m1_addr_ok, m0_addr_ok} !== 2'b00) begin
                errors++;
                $display("FAIL lock_hold cyc=%0d got addr=%h req=%b ok=%b want addr=00002000 req=1 ok=00", i, s_addr, s_req, {m1_addr_ok, m0_addr_ok});
            end
            cycle();
            m0_req = 1;
        end
        s_addr_ok = 1;
        #1;
        checks++;
        if ({m1_addr_ok, m0_addr_ok} !== 2'b10 || s_addr !== 32'h2000) begin
            errors++;
            $display("FAIL lock_accept_m1 got ok=%b addr=%h want ok=10 addr=00002000", {m1_addr_ok, m0_addr_ok}, s_addr);
        end
        exp_q.push_back(1'b1);
        cycle();
        m1_req = 0;
        #1;
        checks++;
        if ({m1_addr_ok, m0_addr_ok} !== 2'b01 || s_addr !== 32'h3000) begin
            errors++;
            $display("FAIL lock_accept_m0 got ok=%b addr=%h want ok=01 addr=00003000", {m1_addr_ok, m0_addr_ok}, s_addr);
        end
        exp_q.push_back(1'b0);
        cycle();
        m0_req = 0; s_addr_ok = 0;
        $display("lock test accepts done");
        resp_drain(2);
    endtask

    task automatic test_full();
        do_reset();
        accept_one(1'b0, 32'h100);
        accept_one(1'b1, 32'h200);
        accept_one(1'b1, 32'h300);
        accept_one(1'b0, 32'h400);
        m0_req = 1; m0_addr = 32'h500; s_addr_ok = 1;
        #1;
        checks++;
        if ({s_req, m1_addr_ok, m0_addr_ok} !== 3'b000) begin
            errors++;
            $display("FAIL full_block got=%b want=000", {s_req, m1_addr_ok, m0_addr_ok});
        end
        cycle();
        m0_req = 0; s_addr_ok = 0;
        resp_drain(4);
    endtask

    task automatic test_simul();
        logic e;
        do_reset();
        accept_one(1'b0, 32'h10);
        accept_one(1'b1, 32'h20);
        m1_req = 1; m1_addr = 32'h4000; s_addr_ok = 1;
        s_data_ok = 1; s_rdata = 32'h5555AAAA;
        #1;
        checks++;
        if ({m1_addr_ok, m0_addr_ok} !== 2'b10) begin
            errors++;
            $display("FAIL simul_accept got=%b want=10", {m1_addr_ok, m0_addr_ok});
        end
        e = exp_q.pop_front();
        checks++;
        if ({m1_data_ok, m0_data_ok} !== (e ? 2'b10 : 2'b01) || m0_rdata !== 32'h5555AAAA) begin
            errors++;
            $display("FAIL simul_resp got ok=%b rdata=%h want owner=%0d rdata=5555aaaa", {m1_data_ok, m0_data_ok}, m0_rdata, e);
        end
        exp_q.push_back(1'b1);
        cycle();
        m1_req = 0; s_addr_ok = 0; s_data_ok = 0;
        #1;
        checks++;
        if (dut.u_fifo.count !== 3'd2) begin
            errors++;
            $display("FAIL simul_count got=%0d want=2", dut.u_fifo.count);
        end
        $display("simultaneous push/pop done");
        resp_drain(2);
    endtask

    task automatic test_unexp();
        do_reset();
        s_data_ok = 1;
        #1;
        checks++;
        if ({m1_data_ok, m0_data_ok} !== 2'b00) begin
            errors++;
            $display("FAIL unexp_no_resp got=%b want=00", {m1_data_ok, m0_data_ok});
        end
        cycle();
        s_data_ok = 0;
        repeat (3) cycle();
        checks++;
        if (err_unexp !== 1'b1) begin
            errors++;
            $display("FAIL unexp_sticky got=%b want=1", err_unexp);
        end
        do_reset();
        #1;
        checks++;
        if (err_unexp !== 1'b0 || dut.u_fifo.count !== 3'd0) begin
            errors++;
            $display("FAIL unexp_reset got err=%b count=%0d want err=0 count=0", err_unexp, dut.u_fifo.count);
        end
        // Reset with a tag outstanding: the late response must be flagged.
        accept_one(1'b0, 32'h80);
        do_reset();
        s_data_ok = 1;
        #1;
        checks++;
        if ({m1_data_ok, m0_data_ok} !== 2'b00) begin
            errors++;
            $display("FAIL late_resp_route got=%b want=00", {m1_data_ok, m0_data_ok});
        end
        cycle();
        s_data_ok = 0;
        #1;
        checks++;
        if (err_unexp !== 1'b1) begin
            errors++;
            $display("FAIL late_resp_err got=%b want=1", err_unexp);
        end
        $display("unexpected response checks done");
    endtask

    initial begin
        idle();
        cycle();
        test_reset();
        test_single_read();
        test_arbitration();
        test_lock();
        test_full();
        test_simul();
        test_unexp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
